// File: rtl/alu_op_sequencer.sv
// Requester-side sequencer for a combinational ALU: valid/ready request in, captured result/flags out.
// Define ALU_SEQ_MUL_EN to build the iterated-add unsigned multiply; otherwise MUL requests return rsp_err.
module alu_op_sequencer #(
  parameter int SIZE      = 32,
  parameter int ALUC_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [SIZE-1:0]      req_a,
  input  logic [SIZE-1:0]      req_b,
  output logic [ALUC_SIZE-1:0] alu_control,
  output logic [SIZE-1:0]      operand0,
  output logic [SIZE-1:0]      operand1,
  input  logic [SIZE-1:0]      alu_result,
  input  logic                 alu_c,
  input  logic                 alu_s,
  input  logic                 alu_v,
  input  logic                 alu_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SIZE-1:0]      rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [ALUC_SIZE-1:0] ALU_QUIET = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, MUL, RESP} state_t;

  state_t state;
  logic   err_pending;

`ifdef ALU_SEQ_MUL_EN
  localparam int                 CNT_W    = $clog2(SIZE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SIZE - 1);
  localparam logic [ALUC_SIZE-1:0] ALU_ADD = '0;

  logic [SIZE-1:0]  mplier;
  logic [CNT_W-1:0] cnt;
  logic [SIZE-1:0]  acc_next;

  // operand0 doubles as the accumulator and operand1 as the shifting multiplicand
  always_comb acc_next = mplier[0] ? alu_result : operand0;
`endif

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      err_pending <= 1'b0;
      alu_control <= ALU_QUIET;
      operand0    <= '0;
      operand1    <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_err     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mplier      <= '0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_op[3]) begin
`ifdef ALU_SEQ_MUL_EN
              state       <= MUL;
              err_pending <= 1'b0;
              alu_control <= ALU_ADD;
              operand0    <= '0;
              operand1    <= req_a;
              mplier      <= req_b;
              cnt         <= '0;
`else
              state       <= ISSUE;
              err_pending <= 1'b1;
`endif
            end else begin
              state       <= ISSUE;
              err_pending <= 1'b0;
              alu_control <= ALUC_SIZE'(req_op[2:0]);
              operand0    <= req_a;
              operand1    <= req_b;
            end
          end
        end

        ISSUE: begin
          rsp_result  <= err_pending ? '0 : alu_result;
          rsp_flags   <= err_pending ? 4'b0000 : {alu_c, alu_s, alu_v, alu_z};
          rsp_err     <= err_pending;
          alu_control <= ALU_QUIET;
          operand0    <= '0;
          operand1    <= '0;
          state       <= RESP;
        end

`ifdef ALU_SEQ_MUL_EN
        MUL: begin
          operand0 <= acc_next;
          operand1 <= operand1 << 1;
          mplier   <= mplier >> 1;
          cnt      <= cnt + 1'b1;
          // Always SIZE iterations, even once the multiplier has run out of ones
          if (cnt == CNT_LAST) begin
            rsp_result  <= acc_next;
            rsp_flags   <= {3'b000, acc_next == '0};
            rsp_err     <= 1'b0;
            alu_control <= ALU_QUIET;
            operand0    <= '0;
            operand1    <= '0;
            state       <= RESP;
          end
        end
`endif

        RESP: begin
          // rsp_valid rises one cycle after entry so the response is never raised with captures in flight
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
